// File: rtl/coin_feeder_if.sv
// Coin feeder signal bundle: coin sensors and vend indication in; coin code,
// FIFO status and vend statistics out.
interface coin_feeder_if;
    logic       nickel_in;
    logic       dime_in;
    logic       newspaper;
    logic [1:0] coin;
    logic       fifo_full;
    logic       reject;
    logic [4:0] credit;
    logic [7:0] sold_count;
    logic       vend_err;

    modport master (
        output nickel_in, dime_in, newspaper,
        input  coin, fifo_full, reject, credit, sold_count, vend_err
    );

    modport slave (
        input  nickel_in, dime_in, newspaper,
        output coin, fifo_full, reject, credit, sold_count, vend_err
    );
endinterface

// File: rtl/coin_feeder.sv
// Coin feeder: queues sensed coins in a 1-bit FIFO and presents them one at a
// time to the vending FSM, tracking credit, completed vends and vend timeouts.
module coin_feeder #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned VEND_TIMEOUT = 15
) (
    input  logic          clock,
    input  logic          reset,
    coin_feeder_if.slave  bus
);

    localparam int unsigned     AW         = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT   = (AW+1)'(DEPTH);
    localparam logic [7:0]      TIMER_LAST = 8'(VEND_TIMEOUT - 1);
    localparam logic [1:0]      COIN_NONE  = 2'b00;
    localparam logic [1:0]      COIN_NICK  = 2'b01;
    localparam logic [1:0]      COIN_DIME  = 2'b10;

    typedef enum logic [1:0] {IDLE, DRIVE, GAP, VEND} state_t;

    state_t             state_q, state_d;
    logic [DEPTH-1:0]   mem_q, mem_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic [1:0]         coin_q, coin_d;
    logic               reject_q, reject_d;
    logic [4:0]         credit_q, credit_d;
    logic [7:0]         sold_q, sold_d;
    logic               vend_err_q, vend_err_d;
    logic [7:0]         timer_q, timer_d;

    logic full, one_coin, push, pop;

    always_comb begin
        state_d    = state_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        coin_d     = COIN_NONE;
        reject_d   = 1'b0;
        credit_d   = credit_q;
        sold_d     = sold_q;
        vend_err_d = vend_err_q;
        timer_d    = timer_q;

        // Fullness uses the registered count, so a pop this cycle does not free a slot for a push.
        full     = (count_q == FULL_CNT);
        one_coin = bus.nickel_in ^ bus.dime_in;
        push     = one_coin & ~full;
        pop      = (state_q == IDLE) && (count_q != '0);
        reject_d = (bus.nickel_in & bus.dime_in) | (one_coin & full);

        if (push) begin
            mem_d[wr_ptr_q] = bus.dime_in;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (pop) begin
                    coin_d   = mem_q[rd_ptr_q] ? COIN_DIME : COIN_NICK;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                credit_d = credit_q + ((coin_q == COIN_DIME) ? 5'd10 : 5'd5);
                if (credit_d >= 5'd15) begin
                    timer_d = '0;
                    state_d = VEND;
                end else begin
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            VEND: begin
                if (bus.newspaper) begin
                    credit_d = '0;
                    sold_d   = sold_q + 1'b1;
                    state_d  = GAP;
                end else if (timer_q == TIMER_LAST) begin
                    credit_d   = '0;
                    vend_err_d = 1'b1;
                    state_d    = GAP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            mem_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            coin_q     <= COIN_NONE;
            reject_q   <= 1'b0;
            credit_q   <= '0;
            sold_q     <= '0;
            vend_err_q <= 1'b0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            coin_q     <= coin_d;
            reject_q   <= reject_d;
            credit_q   <= credit_d;
            sold_q     <= sold_d;
            vend_err_q <= vend_err_d;
            timer_q    <= timer_d;
        end
    end

    assign bus.coin       = coin_q;
    assign bus.fifo_full  = (count_q == FULL_CNT);
    assign bus.reject     = reject_q;
    assign bus.credit     = credit_q;
    assign bus.sold_count = sold_q;
    assign bus.vend_err   = vend_err_q;

endmodule
